nback_prbs_gen: RTL and testbench

//  Pseudo-random bit source for the n-back game: the supplying end of the prbs/ack bit interface

---
 rtl/nback_prbs_gen.sv | 151 +++++++++++++++
 tb/tb_nback_prbs_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nback_prbs_gen.sv
// Purpose : pseudo-random bit source for the n-back game (LFSR with warm-up,
//           entropy reseed and all-zero lock-up recovery).
// Latency : zero; the current bit is shown before ack, and ack consumes it on the clock edge.
// Backpr. : a bit is held (the LFSR does not advance) until prbs_ack_i is seen while valid.
//
// Ports:
//   clk_i          clock
//   a_rst_i        asynchronous active-high reset; release is expected to be
//                  synchronous to clk_i, which upstream reset logic provides
//   seed_stb_i     one-cycle strobe: reseed from the free-running entropy counter
//   prbs_o         current random bit, forced to 0 while prbs_valid_o is low
//   prbs_valid_o   prbs_o carries a usable bit
//   prbs_ack_i     consumer takes prbs_o this cycle
//   consumed_cnt_o number of accepted acks, wraps silently
//   lockup_o       one-cycle pulse after an all-zero LFSR was detected and recovered

module nback_prbs_gen #(
  parameter int unsigned PRBS_W = 15,
  parameter int unsigned SEED   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             a_rst_i,
  input  logic             seed_stb_i,
  output logic             prbs_o,
  output logic             prbs_valid_o,
  input  logic             prbs_ack_i,
  output logic [CNT_W-1:0] consumed_cnt_o,
  output logic             lockup_o
);

  // Second feedback tap (1-based); the first tap is always the MSB.
  localparam int unsigned TAP_B = (PRBS_W == 7)  ? 6  :
                                  (PRBS_W == 9)  ? 5  :
                                  (PRBS_W == 15) ? 14 :
                                  (PRBS_W == 23) ? 18 : 28;

  localparam int unsigned       WARM_W    = $clog2(PRBS_W);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(PRBS_W - 1);
  localparam logic [PRBS_W-1:0] SEED_V    = PRBS_W'(SEED);

  if (!(PRBS_W == 7 || PRBS_W == 9 || PRBS_W == 15 || PRBS_W == 23 || PRBS_W == 31))
  begin : g_bad_width
    $error("nback_prbs_gen: PRBS_W must be one of 7, 9, 15, 23, 31");
  end

  if (SEED_V == '0) begin : g_bad_seed
    $error("nback_prbs_gen: SEED must be non-zero in its PRBS_W low bits");
  end

  typedef enum logic {
    WARMUP_S = 1'b0,
    READY_S  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PRBS_W-1:0]  lfsr, lfsr_d;
  logic [PRBS_W-1:0]  ent_cnt;
  logic [WARM_W-1:0]  warm_cnt, warm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lockup_q, lockup_d;

  logic               fb;
  logic [PRBS_W-1:0]  lfsr_shift;
  logic [PRBS_W-1:0]  reseed_val;
  logic               lfsr_zero;

  assign fb         = lfsr[PRBS_W-1] ^ lfsr[TAP_B-1];
  assign lfsr_shift = {lfsr[PRBS_W-2:0], fb};
  // An entropy value of zero would load the lock-up state, so it maps to SEED.
  assign reseed_val = (ent_cnt == '0) ? SEED_V : ent_cnt;
  assign lfsr_zero  = (lfsr == '0);

  // Entropy source: free-running, deliberately unaffected by reseeding so that
  // the seed depends on when the user presses the button.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      ent_cnt <= '0;
    end else begin
      ent_cnt <= ent_cnt + PRBS_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q  <= WARMUP_S;
      lfsr     <= SEED_V;
      warm_cnt <= '0;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr     <= lfsr_d;
      warm_cnt <= warm_d;
      cnt_q    <= cnt_d;
      lockup_q <= lockup_d;
    end
  end

  // Priority: lock-up recovery, then reseed, then normal warm-up / consume.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr;
    warm_d   = warm_cnt;
    cnt_d    = cnt_q;
    lockup_d = 1'b0;

    if (lfsr_zero) begin
      // Ack and strobe in this cycle are dropped on purpose.
      lfsr_d   = SEED_V;
      state_d  = WARMUP_S;
      warm_d   = '0;
      lockup_d = 1'b1;
    end else if (seed_stb_i) begin
      // The bit shown this cycle still counts if it was acked; the reload
      // replaces the shift it would otherwise have caused.
      lfsr_d  = reseed_val;
      state_d = WARMUP_S;
      warm_d  = '0;
      if (state_q == READY_S && prbs_ack_i) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      unique case (state_q)
        WARMUP_S: begin
          lfsr_d = lfsr_shift;
          warm_d = warm_cnt + WARM_W'(1);
          if (warm_cnt == WARM_LAST) begin
            state_d = READY_S;
            warm_d  = '0;
          end
        end
        READY_S: begin
          if (prbs_ack_i) begin
            lfsr_d = lfsr_shift;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = WARMUP_S;
        end
      endcase
    end
  end

  assign prbs_valid_o   = (state_q == READY_S);
  assign prbs_o         = prbs_valid_o & lfsr[PRBS_W-1];
  assign consumed_cnt_o = cnt_q;
  assign lockup_o       = lockup_q;

endmodule

// File: tb/tb_nback_prbs_gen.sv
module tb_nback_prbs_gen;

  localparam int W    = 7;
  localparam int SEED = 1;
  localparam int CW   = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int CMSK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_stb = 1'b0;
  logic          ack = 1'b0;
  logic          prbs;
  logic          prbs_valid;
  logic          lockup;
  logic [CW-1:0] cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (plain integers, rule-level behaviour).
  int m_lfsr;
  int m_warm_left;
  int m_cnt;
  int m_ent;
  bit m_ready;
  bit m_lock;

  always #5 clk = ~clk;

  nback_prbs_gen #(.PRBS_W(W), .SEED(SEED), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .a_rst_i        (rst),
    .seed_stb_i     (seed_stb),
    .prbs_o         (prbs),
    .prbs_valid_o   (prbs_valid),
    .prbs_ack_i     (ack),
    .consumed_cnt_o (cnt),
    .lockup_o       (lockup)
  );

  // x^7 + x^6 + 1: new bit = bit7 xor bit6 (1-based), appended at the bottom.
  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 6) ^ (v >> 5)) & 1;
    return ((v << 1) | fb) & MASK;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_lfsr      = SEED;
    m_warm_left = W;
    m_cnt       = 0;
    m_ent       = 0;
    m_ready     = 1'b0;
    m_lock      = 1'b0;
  endtask

  task automatic model_step(input bit a, input bit s, input bit zero_forced);
    m_lock = 1'b0;
    if (m_lfsr == 0 || zero_forced) begin
      m_lfsr = SEED; m_ready = 1'b0; m_warm_left = W; m_lock = 1'b1;
    end else if (s) begin
      if (m_ready && a) m_cnt = (m_cnt + 1) & CMSK;
      m_lfsr = (m_ent == 0) ? SEED : m_ent;
      m_ready = 1'b0; m_warm_left = W;
    end else if (!m_ready) begin
      m_lfsr = lfsr_next(m_lfsr);
      m_warm_left--;
      if (m_warm_left == 0) m_ready = 1'b1;
    end else if (a) begin
      m_lfsr = lfsr_next(m_lfsr);
      m_cnt = (m_cnt + 1) & CMSK;
    end
    m_ent = (m_ent + 1) & MASK;
  endtask

  task automatic check_model(input string name);
    int ev, ep;
    ev = m_ready ? 1 : 0;
    ep = m_ready ? ((m_lfsr >> (W - 1)) & 1) : 0;
    n_total++;
    if (int'(prbs_valid) != ev || int'(prbs) != ep || int'(cnt) != m_cnt || int'(lockup) != int'(m_lock))
      $display("FAIL %s: got v=%0d b=%0d c=%0d l=%0d expected v=%0d b=%0d c=%0d l=%0d",
               name, prbs_valid, prbs, cnt, lockup, ev, ep, m_cnt, m_lock);
    else n_pass++;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick_f(input bit a, input bit s, input bit zf);
    ack = a; seed_stb = s;
    @(posedge clk);
    model_step(a, s, zf);
    @(negedge clk);
    ack = 1'b0; seed_stb = 1'b0;
  endtask

  task automatic tick(input bit a, input bit s);
    tick_f(a, s, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ack = 1'b0; seed_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!prbs_valid && n < 50) begin
      n++;
      tick(1'b0, 1'b0);
    end
  endtask

  typedef struct {
    bit ack;
    int exp_valid;
    int exp_prbs;
    int exp_cnt;
    int exp_lfsr;
  } vec_t;

  vec_t vecs[18];
  bit   bits[0:253];

  initial begin
    int n, ones, mism, changes, p0, l0, c0, e0;

    // ack, valid, prbs, cnt, lfsr -- first 18 cycles after reset release
    vecs[0]  = '{1, 0, 0, 0, 'h01};
    vecs[1]  = '{0, 0, 0, 0, 'h02};
    vecs[2]  = '{1, 0, 0, 0, 'h04};
    vecs[3]  = '{1, 0, 0, 0, 'h08};
    vecs[4]  = '{0, 0, 0, 0, 'h10};
    vecs[5]  = '{1, 0, 0, 0, 'h20};
    vecs[6]  = '{1, 0, 0, 0, 'h41};
    vecs[7]  = '{0, 1, 0, 0, 'h03};
    vecs[8]  = '{1, 1, 0, 0, 'h03};
    vecs[9]  = '{1, 1, 0, 1, 'h06};
    vecs[10] = '{1, 1, 0, 2, 'h0C};
    vecs[11] = '{0, 1, 0, 3, 'h18};
    vecs[12] = '{1, 1, 0, 3, 'h18};
    vecs[13] = '{1, 1, 0, 4, 'h30};
    vecs[14] = '{0, 1, 1, 5, 'h61};
    vecs[15] = '{1, 1, 1, 5, 'h61};
    vecs[16] = '{1, 1, 1, 6, 'h42};
    vecs[17] = '{0, 1, 0, 7, 'h05};

    // Reset state while reset is held.
    @(negedge clk);
    chk("rst_valid", int'(prbs_valid), 0);
    chk("rst_prbs", int'(prbs), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_lockup", int'(lockup), 0);
    chk("rst_lfsr", int'(dut.lfsr), SEED);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Table: warm-up ignores ack, then zero-latency consume.
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("vec%0d_valid", i), int'(prbs_valid), vecs[i].exp_valid);
      chk($sformatf("vec%0d_prbs", i), int'(prbs), vecs[i].exp_prbs);
      chk($sformatf("vec%0d_cnt", i), int'(cnt), vecs[i].exp_cnt);
      chk($sformatf("vec%0d_lfsr", i), int'(dut.lfsr), vecs[i].exp_lfsr);
      tick(vecs[i].ack, 1'b0);
    end

    // Full period with ack held high.
    do_reset();
    wait_ready(n);
    chk("warmup_len", n, W);
    for (int i = 0; i < 254; i++) begin
      bits[i] = prbs;
      tick(1'b1, 1'b0);
    end
    mism = 0; ones = 0;
    for (int i = 0; i < 127; i++) begin
      if (bits[i] != bits[i + 127]) mism++;
      if (bits[i]) ones++;
    end
    chk("period_repeat", mism, 0);
    chk("period_ones", ones, 64);
    chk("period_cnt", int'(cnt), 254);
    check_model("period_model");

    // Hold with ack low, then a single ack.
    p0 = int'(prbs); l0 = int'(dut.lfsr); c0 = int'(cnt); changes = 0;
    repeat (100) begin
      tick(1'b0, 1'b0);
      if (int'(prbs) != p0 || int'(dut.lfsr) != l0 || int'(cnt) != c0) changes++;
    end
    chk("hold_changes", changes, 0);
    tick(1'b1, 1'b0);
    chk("single_shift", int'(dut.lfsr), lfsr_next(l0));
    chk("single_cnt", int'(cnt), (c0 + 1) & CMSK);

    // Reseed at ent_cnt == 0 falls back to SEED.
    n = 0;
    while (m_ent != 0 && n < 300) begin n++; tick(1'b0, 1'b0); end
    chk("ent_track", int'(dut.ent_cnt), m_ent);
    tick(1'b0, 1'b1);
    chk("seed0_lfsr", int'(dut.lfsr), SEED);
    chk("seed0_valid", int'(prbs_valid), 0);
    wait_ready(n);
    chk("seed0_warm", n, W);

    // Reseed at ent_cnt == 0x2A.
    n = 0;
    while (m_ent != 'h2A && n < 300) begin n++; tick(1'b0, 1'b0); end
    tick(1'b0, 1'b1);
    chk("seed2a_lfsr", int'(dut.lfsr), 'h2A);
    wait_ready(n);
    chk("seed2a_warm", n, W);

    // Ack and strobe together in READY.
    tick(1'b1, 1'b0);
    c0 = int'(cnt); e0 = m_ent;
    tick(1'b1, 1'b1);
    chk("ackseed_cnt", int'(cnt), (c0 + 1) & CMSK);
    chk("ackseed_valid", int'(prbs_valid), 0);
    chk("ackseed_lfsr", int'(dut.lfsr), (e0 == 0) ? SEED : e0);
    tick(1'b1, 1'b0);
    chk("ackseed_cnt_hold", int'(cnt), (c0 + 1) & CMSK);

    // Lock-up recovery: all-zero detection forced for one edge.
    wait_ready(n);
    tick(1'b1, 1'b0);
    c0 = int'(cnt);
    force dut.lfsr_zero = 1'b1;
    tick_f(1'b1, 1'b1, 1'b1);
    release dut.lfsr_zero;
    chk("lock_pulse", int'(lockup), 1);
    chk("lock_lfsr", int'(dut.lfsr), SEED);
    chk("lock_cnt", int'(cnt), c0);
    chk("lock_valid", int'(prbs_valid), 0);
    tick(1'b0, 1'b0);
    chk("lock_pulse_end", int'(lockup), 0);
    n = 1;
    while (!prbs_valid && n < 50) begin n++; tick(1'b0, 1'b0); end
    chk("lock_warm", n, W);

    // Counter wrap 255 -> 0.
    n = 0;
    while (!(m_cnt == CMSK && m_ready) && n < 2000) begin n++; tick(1'b1, 1'b0); end
    chk("wrap_pre", int'(cnt), CMSK);
    tick(1'b1, 1'b0);
    chk("wrap_zero", int'(cnt), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bit ra, rs;
      ra = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 99) < 2);
      check_model($sformatf("rand%0d", i));
      tick(ra, rs);
    end
    check_model("rand_end");

    // Asynchronous reset in READY with ack high.
    wait_ready(n);
    repeat (3) tick(1'b1, 1'b0);
    chk("arst_pre_cnt_nz", (int'(cnt) != 0) ? 1 : 0, 1);
    ack = 1'b1;
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(prbs_valid), 0);
    chk("arst_prbs", int'(prbs), 0);
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_lockup", int'(lockup), 0);
    @(negedge clk);
    ack = 1'b0;
    rst = 1'b0;
    model_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
